// File: rtl/fb_port_arbiter.sv
// Single-port frame-buffer arbiter: fixed scan-out read slots, with the
// remaining RAM cycles shared by a clear engine and a queued writer port.
module fb_port_arbiter #(
    parameter int FB_W     = 160,
    parameter int FB_H     = 120,
    parameter int SCALE_SH = 2,
    parameter int DW       = 8,
    parameter int AW       = 15,
    parameter int QDEPTH   = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [9:0]    counter_x,
    input  logic [9:0]    counter_y,
    input  logic          wr_valid,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    output logic          wr_ready,
    input  logic          clear_req,
    input  logic [DW-1:0] clear_color,
    output logic          clear_busy,
    output logic          clear_done,
    output logic [AW-1:0] ram_addr,
    output logic          ram_we,
    output logic [DW-1:0] ram_wdata,
    input  logic [DW-1:0] ram_rdata,
    output logic [DW-1:0] pixel_out,
    output logic          pixel_valid
);

    localparam int            FB_SIZE = FB_W * FB_H;
    localparam logic [AW-1:0] LAST    = AW'(FB_SIZE - 1);
    localparam logic [AW-1:0] LIMIT   = AW'(FB_SIZE);
    localparam logic [9:0]    ACT_W   = 10'(FB_W << SCALE_SH);
    localparam logic [9:0]    ACT_H   = 10'(FB_H << SCALE_SH);
    localparam int            QW      = $clog2(QDEPTH);

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t state_q, state_d;

    logic          active, rd_slot;
    logic [AW-1:0] rd_addr;
    logic          clr_wr, clr_last, pop, push, full;
    logic [AW-1:0] caddr;
    logic [DW-1:0] ccolor;
    logic [2:0]    act_d;
    logic [1:0]    rd_d;

    logic [AW-1:0] q_addr [QDEPTH];
    logic [DW-1:0] q_data [QDEPTH];
    logic [QW-1:0] wptr, rptr;
    logic [QW:0]   count;

    assign active  = (counter_x < ACT_W) && (counter_y < ACT_H);
    assign rd_slot = active && (counter_x[SCALE_SH-1:0] == '0);
    assign rd_addr = AW'(counter_y[9:SCALE_SH]) * AW'(FB_W)
                   + AW'(counter_x[9:SCALE_SH]);

    assign full     = (count == (QW+1)'(QDEPTH));
    assign wr_ready = !reset && !full;
    assign push     = wr_valid && wr_ready;

    always_ff @(posedge clk) begin
        if (push) begin
            q_addr[wptr] <= wr_addr;
            q_data[wptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) wptr <= wptr + QW'(1);
            if (pop)  rptr <= rptr + QW'(1);
            unique case ({push, pop})
                2'b10:   count <= count + (QW+1)'(1);
                2'b01:   count <= count - (QW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (clear_req) state_d = CLEAR;
            CLEAR:   if (clr_last)  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        clear_busy = (state_q == CLEAR);
        clr_wr     = (state_q == CLEAR) && !rd_slot;
        clr_last   = clr_wr && (caddr == LAST);
        pop        = (state_q == IDLE) && !rd_slot && (count != '0);
    end

    // ram_addr only moves on a read or a real write; idle and dropped slots hold it
    always_ff @(posedge clk) begin
        if (reset) begin
            ram_addr   <= '0;
            ram_we     <= 1'b0;
            ram_wdata  <= '0;
            caddr      <= '0;
            ccolor     <= '0;
            clear_done <= 1'b0;
        end else begin
            ram_we     <= 1'b0;
            clear_done <= clr_last;
            if (rd_slot) begin
                ram_addr <= rd_addr;
            end else if (clr_wr) begin
                ram_addr  <= caddr;
                ram_we    <= 1'b1;
                ram_wdata <= ccolor;
                caddr     <= caddr + AW'(1);
            end else if (pop && (q_addr[rptr] < LIMIT)) begin
                ram_addr  <= q_addr[rptr];
                ram_we    <= 1'b1;
                ram_wdata <= q_data[rptr];
            end
            if ((state_q == IDLE) && clear_req) begin
                caddr  <= '0;
                ccolor <= clear_color;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            act_d     <= '0;
            rd_d      <= '0;
            pixel_out <= '0;
        end else begin
            act_d <= {act_d[1:0], active};
            rd_d  <= {rd_d[0], rd_slot};
            if (rd_d[1]) pixel_out <= ram_rdata;
        end
    end

    assign pixel_valid = act_d[2];

endmodule
